// File: rtl/btn_event_pkg.sv
// Shared register map for the button event reader: bus addresses and
// bit offsets of the STATUS fields.
package btn_event_pkg;

  localparam logic BTN_ADDR_STATUS = 1'b0;
  localparam logic BTN_ADDR_CTRL   = 1'b1;

  localparam int BTN_STATE_LSB = 0;
  localparam int BTN_PRESS_LSB = 8;
  localparam int BTN_REL_LSB   = 16;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, hold-time debounce counter and the accepted
// level, with single-cycle pulses on the cycle a new level is accepted.
module btn_debounce #(
  parameter int DBW      = 16,
  parameter int DEBOUNCE = 48000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [DBW-1:0] CNT_LAST = DBW'(DEBOUNCE - 1);

  logic           sync1_r;
  logic           sync2_r;
  logic           stable_r;
  logic [DBW-1:0] cnt_r;
  logic           accept_s;

  // Pulses line up with the edge that updates stable_r, so the pending bits
  // upstream become visible in the same cycle as the new stable level.
  assign accept_s = (sync2_r != stable_r) && (cnt_r == CNT_LAST);
  assign rise     = accept_s & sync2_r;
  assign fall     = accept_s & ~sync2_r;
  assign stable   = stable_r;

  // Synchronise the raw input and count how long it disagrees with stable_r.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= {DBW{1'b0}};
    end else begin
      sync1_r <= i_btn;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        cnt_r <= {DBW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= sync2_r;
        cnt_r    <= {DBW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(DBW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/btn_event.sv
// Wishbone button reader: debounced levels, W1C press/release pending bits,
// per-event interrupt enables and a registered level interrupt.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int NBTN     = 2,
  parameter int DBW      = 16,
  parameter int DEBOUNCE = 48000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic            i_wb_addr,
  input  logic [31:0]     i_wb_data,
  input  logic [3:0]      i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [31:0]     o_wb_data,
  input  logic [NBTN-1:0] i_btn,
  output logic            o_int
);

  logic [NBTN-1:0] stable_s;
  logic [NBTN-1:0] rise_s;
  logic [NBTN-1:0] fall_s;
  logic [NBTN-1:0] press_r;
  logic [NBTN-1:0] rel_r;
  logic [NBTN-1:0] press_en_r;
  logic [NBTN-1:0] rel_en_r;
  logic [NBTN-1:0] press_clr_s;
  logic [NBTN-1:0] rel_clr_s;
  logic [31:0]     rdata_s;
  logic [31:0]     data_r;
  logic            ack_r;
  logic            int_r;
  logic            ctrl_wr_s;
  logic            unused_s;

  for (genvar k = 0; k < NBTN; k++) begin : g_btn
    btn_debounce #(
      .DBW      (DBW),
      .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_btn   (i_btn[k]),
      .stable  (stable_s[k]),
      .rise    (rise_s[k]),
      .fall    (fall_s[k])
    );
  end

  assign unused_s   = &{1'b0, i_wb_cyc, i_wb_sel[3], i_wb_data};
  assign ctrl_wr_s  = i_wb_stb && i_wb_we && (i_wb_addr == BTN_ADDR_CTRL);
  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = ack_r;
  assign o_wb_data  = data_r;
  assign o_int      = int_r;

  // Read mux and STATUS write-one-to-clear masks.
  always_comb begin
    rdata_s     = 32'h0000_0000;
    press_clr_s = {NBTN{1'b0}};
    rel_clr_s   = {NBTN{1'b0}};
    case (i_wb_addr)
      BTN_ADDR_STATUS: begin
        rdata_s[BTN_STATE_LSB +: NBTN] = stable_s;
        rdata_s[BTN_PRESS_LSB +: NBTN] = press_r;
        rdata_s[BTN_REL_LSB   +: NBTN] = rel_r;
      end
      BTN_ADDR_CTRL: begin
        rdata_s[0 +: NBTN] = press_en_r;
        rdata_s[8 +: NBTN] = rel_en_r;
      end
      default: rdata_s = 32'h0000_0000;
    endcase
    if (i_wb_stb && i_wb_we && (i_wb_addr == BTN_ADDR_STATUS)) begin
      press_clr_s = i_wb_sel[1] ? i_wb_data[BTN_PRESS_LSB +: NBTN] : {NBTN{1'b0}};
      rel_clr_s   = i_wb_sel[2] ? i_wb_data[BTN_REL_LSB +: NBTN]   : {NBTN{1'b0}};
    end else begin
      press_clr_s = {NBTN{1'b0}};
      rel_clr_s   = {NBTN{1'b0}};
    end
  end

  // Bus response, pending/enable registers and interrupt. New events are OR-ed
  // in after the clear so an event coinciding with its own W1C survives.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      press_r    <= {NBTN{1'b0}};
      rel_r      <= {NBTN{1'b0}};
      press_en_r <= {NBTN{1'b0}};
      rel_en_r   <= {NBTN{1'b0}};
      ack_r      <= 1'b0;
      data_r     <= 32'h0000_0000;
      int_r      <= 1'b0;
    end else begin
      ack_r <= i_wb_stb;
      if (i_wb_stb) begin
        data_r <= rdata_s;
      end
      press_r <= (press_r & ~press_clr_s) | rise_s;
      rel_r   <= (rel_r & ~rel_clr_s) | fall_s;
      if (ctrl_wr_s && i_wb_sel[0]) begin
        press_en_r <= i_wb_data[0 +: NBTN];
      end
      if (ctrl_wr_s && i_wb_sel[1]) begin
        rel_en_r <= i_wb_data[8 +: NBTN];
      end
      int_r <= (|(press_r & press_en_r)) | (|(rel_r & rel_en_r));
    end
  end

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with NBTN=2, DEBOUNCE=4.
module tb_btn_event;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall, ack, irq;
  logic [31:0] rdata;
  logic [1:0]  btn;
  int          total = 0;
  int          bad = 0;

  btn_event #(.NBTN(2), .DBW(16), .DEBOUNCE(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall),
    .o_wb_ack(ack), .o_wb_data(rdata), .i_btn(btn), .o_int(irq)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle access starting and ending on a falling edge.
  task automatic wb_read(input logic a, output logic [31:0] d, output logic k);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'hf;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    d = rdata; k = ack;
  endtask

  task automatic wb_write(input logic a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic k;
    rst = 1'b1;
    cycles(3);
    total++; if (ack !== 1'b0 || irq !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: ack=%b int=%b stall=%b want 0 0 0", ack, irq, stall); end
    rst = 1'b0;
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0 || k !== 1'b1) begin
      bad++; $display("FAIL reset_status: data=%h ack=%b want 00000000 1", d, k); end
    wb_read(1'b1, d, k);
    total++; if (d !== 32'h0 || k !== 1'b1) begin
      bad++; $display("FAIL reset_ctrl: data=%h ack=%b want 00000000 1", d, k); end
    cycles(1);
    total++; if (ack !== 1'b0) begin
      bad++; $display("FAIL idle_ack: ack=%b want 0", ack); end
  endtask

  task automatic test_press;
    logic [31:0] d; logic k;
    btn[0] = 1'b1;
    cycles(5);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0) begin
      bad++; $display("FAIL press_early: data=%h want 00000000", d); end
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0000_0101) begin
      bad++; $display("FAIL press_seen: data=%h want 00000101", d); end
    cycles(3);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0000_0101) begin
      bad++; $display("FAIL press_reread: data=%h want 00000101", d); end
    wb_write(1'b0, 32'h0000_0100, 4'b0010);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0000_0001) begin
      bad++; $display("FAIL press_w1c: data=%h want 00000001", d); end
    btn[0] = 1'b0;
    cycles(10);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0001_0000) begin
      bad++; $display("FAIL release_seen: data=%h want 00010000", d); end
    wb_write(1'b0, 32'h0001_0000, 4'b0100);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0) begin
      bad++; $display("FAIL release_w1c: data=%h want 00000000", d); end
  endtask

  task automatic test_glitch;
    logic [31:0] d; logic k;
    for (int i = 0; i < 8; i++) begin
      btn[1] = 1'b1; cycles(1);
      btn[1] = 1'b0; cycles(2);
    end
    cycles(6);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL glitch: data=%h int=%b want 00000000 0", d, irq); end
  endtask

  task automatic test_irq;
    logic [31:0] d; logic k;
    wb_write(1'b1, 32'h0000_0200, 4'b0010);
    wb_read(1'b1, d, k);
    total++; if (d !== 32'h0000_0200) begin
      bad++; $display("FAIL ctrl_write: data=%h want 00000200", d); end
    btn[1] = 1'b1;
    cycles(10);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0000_0202 || irq !== 1'b0) begin
      bad++; $display("FAIL press1_masked: data=%h int=%b want 00000202 0", d, irq); end
    btn[1] = 1'b0;
    cycles(6);
    total++; if (irq !== 1'b0) begin
      bad++; $display("FAIL int_early: int=%b want 0", irq); end
    cycles(1);
    total++; if (irq !== 1'b1) begin
      bad++; $display("FAIL int_rise: int=%b want 1", irq); end
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0002_0200) begin
      bad++; $display("FAIL rel1_status: data=%h want 00020200", d); end
    wb_write(1'b0, 32'h0002_0000, 4'b0100);
    total++; if (irq !== 1'b1) begin
      bad++; $display("FAIL int_hold: int=%b want 1", irq); end
    cycles(1);
    total++; if (irq !== 1'b0) begin
      bad++; $display("FAIL int_clear: int=%b want 0", irq); end
    wb_write(1'b0, 32'h0000_0200, 4'b0010);
    wb_write(1'b1, 32'hffff_ffff, 4'b0001);
    wb_read(1'b1, d, k);
    total++; if (d !== 32'h0000_0203) begin
      bad++; $display("FAIL ctrl_sel: data=%h want 00000203", d); end
    wb_write(1'b1, 32'h0000_0000, 4'b0011);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0) begin
      bad++; $display("FAIL irq_cleanup: data=%h want 00000000", d); end
  endtask

  task automatic test_set_wins;
    logic [31:0] d; logic k;
    btn[0] = 1'b1; cycles(10);
    btn[0] = 1'b0; cycles(10);
    btn[0] = 1'b1;
    cycles(5);
    wb_write(1'b0, 32'h0000_0100, 4'b0010);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0001_0101) begin
      bad++; $display("FAIL set_wins: data=%h want 00010101", d); end
    wb_write(1'b0, 32'h0001_0100, 4'b0110);
    btn[0] = 1'b0; cycles(10);
    wb_write(1'b0, 32'h0001_0000, 4'b0100);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0) begin
      bad++; $display("FAIL set_wins_cleanup: data=%h want 00000000", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic k;
    wb_write(1'b1, 32'h0000_0101, 4'b0011);
    btn[0] = 1'b1;
    cycles(3);
    rst = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b0; addr = 1'b0;
    cycles(2);
    total++; if (ack !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL reset_stb: ack=%b data=%h int=%b want 0 00000000 0", ack, rdata, irq); end
    rst = 1'b0; stb = 1'b0; cyc = 1'b0;
    cycles(1);
    total++; if (ack !== 1'b0) begin
      bad++; $display("FAIL reset_noack: ack=%b want 0", ack); end
    cycles(4);
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0) begin
      bad++; $display("FAIL reset_press_early: data=%h want 00000000", d); end
    wb_read(1'b0, d, k);
    total++; if (d !== 32'h0000_0101) begin
      bad++; $display("FAIL reset_press: data=%h want 00000101", d); end
    wb_read(1'b1, d, k);
    total++; if (d !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl_clear: data=%h int=%b want 00000000 0", d, irq); end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 1'b0;
    wdata = 32'h0; sel = 4'h0; btn = 2'b00;
    @(negedge clk);
    test_reset();
    test_press();
    test_glitch();
    test_irq();
    test_set_wins();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
